// File: rtl/riscv_fetch.sv
// RISC-V instruction fetch: PC register, single-cycle-latency imem interface,
// small FIFO fetch buffer feeding decode, with redirect and misaligned-target fault.
module riscv_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   input  logic        id_ready,
   output logic        fetch_fault
);

   localparam int AW = $clog2(BUF_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(BUF_DEPTH);

   logic [31:0]   r_pc;
   logic [31:0]   r_inflight_pc;
   logic          r_inflight;
   logic          r_fault;
   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic [31:0]   r_buf_instr [BUF_DEPTH];
   logic [31:0]   r_buf_pc    [BUF_DEPTH];

   logic          w_redirect;
   logic          w_pop;
   logic          w_write;
   logic [CW:0]   w_occ;

   // A redirect is honoured only while no fault is latched.
   assign w_redirect = br_taken & ~r_fault;

   assign if_valid  = rst & (r_count != '0);
   assign if_instr  = if_valid ? r_buf_instr[r_head] : 32'h0;
   assign if_pc     = if_valid ? r_buf_pc[r_head]    : 32'h0;
   assign w_pop     = if_valid & id_ready & ~br_taken;

   // Slots committed next cycle: buffered + returning response - departing head.
   assign w_occ     = {1'b0, r_count} + (CW + 1)'(r_inflight) - (CW + 1)'(w_pop);
   assign imem_req  = rst & ~r_fault & ~br_taken & (w_occ < DEPTH_C);
   assign imem_addr = rst ? r_pc : RESET_PC;

   assign w_write     = r_inflight & ~w_redirect;
   assign fetch_fault = r_fault;

   always_ff @(posedge clk) begin
      // NOTE: all state uses non-blocking assignments so every register samples
      // pre-edge values, independent of statement order.
      if (!rst) begin
         r_pc          <= RESET_PC;
         r_inflight    <= 1'b0;
         r_inflight_pc <= RESET_PC;
         r_fault       <= 1'b0;
         r_head        <= '0;
         r_tail        <= '0;
         r_count       <= '0;
      end else begin
         r_inflight    <= imem_req;
         r_inflight_pc <= r_pc;
         if (w_redirect) begin
            r_pc    <= br_target;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            if (br_target[1:0] != 2'b00) r_fault <= 1'b1;
         end else begin
            if (imem_req) r_pc   <= r_pc + 32'd4;
            if (w_write)  r_tail <= r_tail + AW'(1);
            if (w_pop)    r_head <= r_head + AW'(1);
            r_count <= r_count + CW'(w_write) - CW'(w_pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: buffer storage is not reset; entries are only observed once the
      // reset pointers/count mark them valid, so a reset here buys nothing.
      if (rst && w_write) begin
         r_buf_instr[r_tail] <= imem_rdata;
         r_buf_pc[r_tail]    <= r_inflight_pc;
      end
   end

endmodule

// File: tb/tb_riscv_fetch.sv
// Self-checking bench for riscv_fetch: memory model, directed cycle checks and
// an in-order scoreboard of PCs decode is expected to accept.
module tb_riscv_fetch;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        br_taken;
   logic [31:0] br_target;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        id_ready;
   logic        fetch_fault;

   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] sb_q[$];
   logic [31:0] sb_exp;

   riscv_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .if_valid    (if_valid),
      .if_instr    (if_instr),
      .if_pc       (if_pc),
      .id_ready    (id_ready),
      .fetch_fault (fetch_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h0040_0a63 ^ {a[21:0], 10'b0};
   endfunction

   // Instruction memory: word returned exactly one cycle after its request.
   always @(posedge clk) imem_rdata <= imem_req ? mem_word(imem_addr) : 32'h0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_seq(input logic [31:0] start, input int n);
      for (int i = 0; i < n; i++) sb_q.push_back(start + 32'(4 * i));
   endtask

   task automatic drain(input int budget);
      for (int n = 0; n < budget; n++) begin
         tick();
         if (sb_q.size() == 0) break;
      end
      check("drain_left", 32'(sb_q.size()), 32'd0);
   endtask

   always @(negedge clk) begin
      if (rst && if_valid && id_ready && !br_taken) begin
         if (sb_q.size() == 0) begin
            check("sb_extra_accept", 32'(if_valid), 32'd0);
         end else begin
            sb_exp = sb_q.pop_front();
            check("sb_pc", if_pc, sb_exp);
            check("sb_instr", if_instr, mem_word(sb_exp));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; br_taken = 1'b0; br_target = 32'h0; id_ready = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      check("rst_req",   32'(imem_req),    32'd0);
      check("rst_addr",  imem_addr,        32'h0);
      check("rst_valid", 32'(if_valid),    32'd0);
      check("rst_instr", if_instr,         32'h0);
      check("rst_pc",    if_pc,            32'h0);
      check("rst_fault", 32'(fetch_fault), 32'd0);

      // Start-up timing, then redirect to 20 while word for 8 is in flight.
      push_seq(32'h0, 2);
      tick(); rst = 1'b1;
      @(negedge clk);
      check("c0_req", 32'(imem_req), 32'd1);
      check("c0_addr", imem_addr, 32'h0);
      check("c0_valid", 32'(if_valid), 32'd0);
      tick(); @(negedge clk);
      check("c1_addr", imem_addr, 32'h4);
      check("c1_valid", 32'(if_valid), 32'd0);
      tick(); @(negedge clk);
      check("c2_addr", imem_addr, 32'h8);
      check("c2_valid", 32'(if_valid), 32'd1);
      check("c2_pc", if_pc, 32'h0);
      tick(); br_taken = 1'b1; br_target = 32'd20;
      sb_q.delete(); push_seq(32'd20, 8);
      @(negedge clk);
      check("redir_noreq", 32'(imem_req), 32'd0);
      tick(); br_taken = 1'b0;
      @(negedge clk);
      check("redir_req", 32'(imem_req), 32'd1);
      check("redir_addr", imem_addr, 32'd20);
      check("redir_valid1", 32'(if_valid), 32'd0);
      tick(); @(negedge clk);
      check("redir_valid2", 32'(if_valid), 32'd0);
      tick(); @(negedge clk);
      check("redir_valid3", 32'(if_valid), 32'd1);
      check("redir_pc", if_pc, 32'd20);
      for (int i = 0; i < 7; i++) begin
         tick(); @(negedge clk);
         check("steady_valid", 32'(if_valid), 32'd1);
      end
      drain(20);
      id_ready = 1'b0;

      // Decode stall: buffer fills to two, requests stop, head holds.
      rst = 1'b0;
      tick(); rst = 1'b1;
      sb_q.delete(); push_seq(32'h0, 10);
      repeat (5) tick();
      @(negedge clk);
      check("stall_noreq", 32'(imem_req), 32'd0);
      check("stall_addr", imem_addr, 32'h8);
      check("stall_valid", 32'(if_valid), 32'd1);
      check("stall_pc", if_pc, 32'h0);
      tick(); @(negedge clk);
      check("stall_hold_pc", if_pc, 32'h0);
      check("stall_hold_instr", if_instr, mem_word(32'h0));
      tick(); id_ready = 1'b1;
      drain(30);

      // Back-to-back redirects: 24 then 0; only 0 is fetched.
      br_taken = 1'b1; br_target = 32'd24;
      push_seq(32'h0, 6);
      @(negedge clk);
      check("bb1_noreq", 32'(imem_req), 32'd0);
      tick(); br_target = 32'd0;
      @(negedge clk);
      check("bb2_noreq", 32'(imem_req), 32'd0);
      check("bb2_valid", 32'(if_valid), 32'd0);
      tick(); br_taken = 1'b0;
      @(negedge clk);
      check("bb_req", 32'(imem_req), 32'd1);
      check("bb_addr", imem_addr, 32'h0);
      drain(30);

      // Misaligned redirect: sticky fault, later redirects ignored.
      br_taken = 1'b1; br_target = 32'd22;
      @(negedge clk);
      check("mis_noreq", 32'(imem_req), 32'd0);
      tick(); br_taken = 1'b0;
      @(negedge clk);
      check("flt_set", 32'(fetch_fault), 32'd1);
      check("flt_noreq", 32'(imem_req), 32'd0);
      check("flt_valid", 32'(if_valid), 32'd0);
      check("flt_addr", imem_addr, 32'd22);
      repeat (3) tick();
      br_taken = 1'b1; br_target = 32'd40;
      tick(); br_taken = 1'b0;
      @(negedge clk);
      check("flt_ign_fault", 32'(fetch_fault), 32'd1);
      check("flt_ign_addr", imem_addr, 32'd22);
      check("flt_ign_req", 32'(imem_req), 32'd0);
      tick(); rst = 1'b0;
      @(negedge clk);
      check("rst2_req", 32'(imem_req), 32'd0);
      check("rst2_addr", imem_addr, 32'h0);
      check("rst2_valid", 32'(if_valid), 32'd0);
      tick(); rst = 1'b1;
      push_seq(32'h0, 3);
      @(negedge clk);
      check("rel_fault", 32'(fetch_fault), 32'd0);
      check("rel_req", 32'(imem_req), 32'd1);
      check("rel_addr", imem_addr, 32'h0);

      // Reset mid-stream with one entry buffered and one in flight.
      tick(); tick(); tick();
      tick(); rst = 1'b0;
      sb_q.delete(); push_seq(32'h0, 6);
      @(negedge clk);
      check("mid_rst_valid", 32'(if_valid), 32'd0);
      tick(); rst = 1'b1;
      @(negedge clk);
      check("mid_c0_req", 32'(imem_req), 32'd1);
      check("mid_c0_addr", imem_addr, 32'h0);
      check("mid_c0_valid", 32'(if_valid), 32'd0);
      tick(); @(negedge clk);
      check("mid_c1_valid", 32'(if_valid), 32'd0);
      tick(); @(negedge clk);
      check("mid_c2_valid", 32'(if_valid), 32'd1);
      check("mid_c2_pc", if_pc, 32'h0);
      drain(30);
      id_ready = 1'b0;
      tick();
      check("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
